// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive stimulus/compare engine for a small combinational block.
// Optional TRUTH_TABLE_SWEEPER_STOP_ON_FAIL_EN ends the sweep on the first mismatch.
module truth_table_sweeper #(
  parameter int N_IN = 3,
  parameter int HOLD_CYCLES = 10,
  parameter logic [(1<<N_IN)-1:0] EXPECT = 8'hEA
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [N_IN:0] ERR_MAX = (N_IN+1)'(1 << N_IN);
  localparam logic [N_IN-1:0] LAST_VEC = '1;
  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
  state_t state, state_nxt;
  logic [HW-1:0] hold;
  logic sample, mismatch, launch, stop;
  logic [N_IN:0] err_nxt;
  always_comb begin
    launch = start && state != APPLY;
    sample = state == APPLY && hold == HOLD_LAST;
    mismatch = sample && dut_out != EXPECT[dut_in];
    err_nxt = (mismatch && err_count != ERR_MAX) ? err_count + 1'b1 : err_count;
`ifdef TRUTH_TABLE_SWEEPER_STOP_ON_FAIL_EN
    stop = sample && (dut_in == LAST_VEC || mismatch);
`else
    stop = sample && dut_in == LAST_VEC;
`endif
    state_nxt = launch ? APPLY : stop ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in <= '0;
      hold <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_fail_vec <= '0;
      first_fail_valid <= 1'b0;
    end else if (launch) begin
      dut_in <= '0;
      hold <= '0;
      busy <= 1'b1;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_fail_vec <= '0;
      first_fail_valid <= 1'b0;
    end else if (state == APPLY) begin
      err_count <= err_nxt;
      if (mismatch && !first_fail_valid) begin
        first_fail_vec <= dut_in;
        first_fail_valid <= 1'b1;
      end
      // pass uses the post-compare count so a miss on the final vector is seen
      if (stop) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= err_nxt == '0;
        hold <= '0;
      end else if (sample) begin
        dut_in <= dut_in + 1'b1;
        hold <= '0;
      end else begin
        hold <= hold + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboard bench driving the sweeper against a modelled DUT.
module tb_truth_table_sweeper;
  localparam int HOLD = 10;
  localparam logic [7:0] TT = 8'hEA;
`ifdef TRUTH_TABLE_SWEEPER_STOP_ON_FAIL_EN
  localparam bit SOF = 1'b1;
`else
  localparam bit SOF = 1'b0;
`endif
  typedef struct {
    int cycles;
    logic [3:0] err;
    logic [2:0] ffv;
    logic ffval;
    logic pass;
    logic [2:0] last;
  } exp_t;
  logic clk = 1'b0, rst_n, start, dut_out, busy, done, pass, first_fail_valid;
  logic [2:0] dut_in, first_fail_vec;
  logic [3:0] err_count;
  logic [1:0] mode;
  int checks = 0, errors = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  function automatic logic f(input logic [2:0] x);
    return (x[2] & x[1]) | x[0];
  endfunction
  function automatic logic resp(input logic [1:0] m, input logic [2:0] x);
    return m == 2'd1 ? 1'b0 : m == 2'd2 ? ~f(x) : f(x);
  endfunction
  assign dut_out = resp(mode, dut_in);
  truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(HOLD), .EXPECT(TT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
  );
  function automatic exp_t model(input logic [1:0] m);
    exp_t e;
    logic [2:0] x;
    e = '{cycles: 8*HOLD, err: 4'd0, ffv: 3'd0, ffval: 1'b0, pass: 1'b1, last: 3'd7};
    for (int v = 0; v < 8; v++) begin
      x = 3'(v);
      if (resp(m, x) != TT[v]) begin
        e.err = e.err + 1'b1;
        if (!e.ffval) begin
          e.ffv = x;
          e.ffval = 1'b1;
        end
        if (SOF) begin
          e.cycles = (v + 1) * HOLD;
          e.last = x;
          break;
        end
      end
    end
    e.pass = e.err == 4'd0;
    return e;
  endfunction
  task automatic check_zero(input string tag);
    checks++;
    if ({dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid} !== 15'd0) begin
      errors++;
      $display("FAIL %s: dut_in=%0d busy=%b done=%b pass=%b err=%0d ffv=%0d ffval=%b, want all 0",
               tag, dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid);
    end
  endtask
  task automatic run_sweep(input logic [1:0] m, input bit hold_start, input string tag);
    exp_t g;
    int n, bad;
    mode = m;
    q.push_back(model(m));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || err_count !== 4'd0 ||
        first_fail_valid !== 1'b0 || dut_in !== 3'd0) begin
      errors++;
      $display("FAIL %s launch: busy=%b done=%b pass=%b err=%0d ffval=%b dut_in=%0d, want 1 0 0 0 0 0",
               tag, busy, done, pass, err_count, first_fail_valid, dut_in);
    end
    n = 0;
    bad = 0;
    while (done !== 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (done !== 1'b1 && (busy !== 1'b1 || dut_in !== 3'(n / HOLD))) bad++;
    end
    start = 1'b0;
    g = q.pop_front();
    checks++;
    if (n != g.cycles) begin
      errors++;
      $display("FAIL %s latency: done after %0d edges, want %0d", tag, n, g.cycles);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s sequence: %0d cycles with wrong dut_in/busy, want 0", tag, bad);
    end
    checks++;
    if (err_count !== g.err || pass !== g.pass || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s result: err=%0d pass=%b busy=%b, want err=%0d pass=%b busy=0",
               tag, err_count, pass, busy, g.err, g.pass);
    end
    checks++;
    if (first_fail_valid !== g.ffval || (g.ffval && first_fail_vec !== g.ffv)) begin
      errors++;
      $display("FAIL %s first_fail: valid=%b vec=%0d, want valid=%b vec=%0d",
               tag, first_fail_valid, first_fail_vec, g.ffval, g.ffv);
    end
    checks++;
    if (dut_in !== g.last) begin
      errors++;
      $display("FAIL %s final dut_in: %0d, want %0d", tag, dut_in, g.last);
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_good;
    run_sweep(2'd0, 1'b0, "good");
  endtask
  task automatic test_stuck;
    run_sweep(2'd1, 1'b0, "stuck0");
  endtask
  task automatic test_inverted;
    run_sweep(2'd2, 1'b0, "inverted");
  endtask
  task automatic test_restart_from_done;
    run_sweep(2'd0, 1'b0, "restart");
  endtask
  task automatic test_async_reset;
    int n;
    mode = 2'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (dut_in !== 3'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dut_in !== 3'd4) begin
      errors++;
      $display("FAIL async wait: dut_in=%0d, want 4 within 100 cycles", dut_in);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset_idle");
    run_sweep(2'd0, 1'b0, "after_reset");
  endtask
  task automatic test_start_held;
    run_sweep(2'd0, 1'b1, "start_held");
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_held stay: done=%b busy=%b, want 1 0", done, busy);
    end
  endtask
  initial begin
    test_reset;
    test_good;
    test_stuck;
    test_inverted;
    test_restart_from_done;
    test_async_reset;
    test_start_held;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
